// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan capture block: hex glyph patterns
// (active-low, bit order {g,f,e,d,c,b,a}), the blank pattern and the
// scan-state enumeration.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational cathode-pattern to hex-nibble decoder. known is low for any
// pattern that is not one of the 16 hex glyphs; nibble is then 0.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       known
);

    // Look the pattern up in the glyph set
    always_comb begin
        nibble = 4'h0;
        known  = 1'b1;
        case (pattern)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: known = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures the digits shown on a multiplexed 8-digit 7-segment display by
// watching its anode/cathode drives. A digit is accepted once its drive has
// been stable for SETTLE_CYCLES samples; a full frame is published when all
// eight positions have been seen.
// Optional feature macro: SEG7_SCAN_DP_CAPTURE_EN (adds dp_out, per-digit
// decimal-point capture).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   WAIT   | idle after reset, no input change seen yet
//   SETTLE | input changed, counting stable samples
//   HELD   | current value accepted (or ignored), wait for next change
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  anode,
    input  logic [6:0]  cathode,
    input  logic        dp,
    input  logic        clear_err,
    output logic [31:0] digits,
    output logic        frame_valid,
    output logic        pattern_err,
    output logic        anode_err
`ifdef SEG7_SCAN_DP_CAPTURE_EN
    ,
    output logic [7:0]  dp_out
`endif
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE_CYCLES);

    logic [15:0] sync_1, sync_2, prev;
    logic [7:0]  cnt;
    logic [7:0]  an_s;
    logic [6:0]  cat_s;
    logic        changed;
    scan_state_t state, state_nxt;
    logic        accept;
    logic [3:0]  low_cnt;
    logic [2:0]  low_idx;
    logic        one_hot, capture, frame_done;
    logic [3:0]  dec_nibble;
    logic        dec_known;
    logic [31:0] stage, stage_nxt;
    logic [7:0]  seen, seen_nxt;

    assign an_s    = sync_2[15:8];
    assign cat_s   = sync_2[7:1];
    assign changed = (sync_2 != prev);

    // Two-flop synchroniser, previous-sample register and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '1;
            sync_2 <= '1;
            prev   <= '1;
            cnt    <= '0;
        end else begin
            sync_1 <= {anode, cathode, dp};
            sync_2 <= sync_1;
            prev   <= sync_2;
            if (changed)
                cnt <= 8'd1;
            else if (cnt < SETTLE_C)
                cnt <= cnt + 8'd1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= WAIT;
        else
            state <= state_nxt;
    end

    // Next state; accept fires only on the SETTLE->HELD transition
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            WAIT:    if (changed) state_nxt = SETTLE;
            SETTLE:  if (!changed && cnt == SETTLE_C) begin
                         state_nxt = HELD;
                         accept    = 1'b1;
                     end
            HELD:    if (changed) state_nxt = SETTLE;
            default: state_nxt = WAIT;
        endcase
    end

    // Count low anode bits and remember which one (valid when exactly one)
    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (!an_s[i]) begin
                low_cnt = low_cnt + 4'd1;
                low_idx = 3'(i);
            end
        end
    end

    seg7_glyph_decode u_decode (
        .pattern (cat_s),
        .nibble  (dec_nibble),
        .known   (dec_known)
    );

    assign one_hot = (low_cnt == 4'd1);
    assign capture = accept && one_hot;

    // Staging slot and seen bit as they will be after this cycle's capture
    always_comb begin
        stage_nxt = stage;
        seen_nxt  = seen;
        if (capture) begin
            stage_nxt[{low_idx, 2'b00} +: 4] = dec_known ? dec_nibble : 4'h0;
            seen_nxt[low_idx]                = 1'b1;
        end
    end

    assign frame_done = capture && (seen_nxt == 8'hFF);

    // Staging, seen mask and frame publication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage       <= '0;
            seen        <= '0;
            digits      <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            stage       <= stage_nxt;
            if (frame_done) begin
                digits <= stage_nxt;
                seen   <= '0;
            end else begin
                seen <= seen_nxt;
            end
        end
    end

    // Sticky error flags; a same-cycle set wins over clear_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_err <= 1'b0;
            anode_err   <= 1'b0;
        end else begin
            if (capture && !dec_known)
                pattern_err <= 1'b1;
            else if (clear_err)
                pattern_err <= 1'b0;
            if (accept && low_cnt >= 4'd2)
                anode_err <= 1'b1;
            else if (clear_err)
                anode_err <= 1'b0;
        end
    end

`ifdef SEG7_SCAN_DP_CAPTURE_EN
    logic [7:0] dp_stage, dp_stage_nxt;

    // Decimal point per digit, stored active-high alongside the nibble
    always_comb begin
        dp_stage_nxt = dp_stage;
        if (capture)
            dp_stage_nxt[low_idx] = ~sync_2[0];
    end

    // Decimal-point staging and publication together with digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_stage <= '0;
            dp_out   <= '0;
        end else begin
            dp_stage <= dp_stage_nxt;
            if (frame_done)
                dp_out <= dp_stage_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture (SETTLE_CYCLES = 4).
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  anode = 8'hFF;
    logic [6:0]  cathode = 7'h7F;
    logic        dp = 1'b1;
    logic        clear_err = 1'b0;
    logic [31:0] digits;
    logic        frame_valid;
    logic        pattern_err;
    logic        anode_err;
`ifdef SEG7_SCAN_DP_CAPTURE_EN
    logic [7:0]  dp_out;
`endif

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;

    seg7_scan_capture #(.SETTLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .anode       (anode),
        .cathode     (cathode),
        .dp          (dp),
        .clear_err   (clear_err),
        .digits      (digits),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err),
        .anode_err   (anode_err)
`ifdef SEG7_SCAN_DP_CAPTURE_EN
        ,
        .dp_out      (dp_out)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_valid) fv_cnt++;

    typedef struct {
        logic [6:0] cat;
        logic [3:0] nib;
        logic       perr;
    } vec_t;

    vec_t vecs[20];

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0:  return 7'h40;  1:  return 7'h79;  2:  return 7'h24;  3:  return 7'h30;
            4:  return 7'h19;  5:  return 7'h12;  6:  return 7'h02;  7:  return 7'h78;
            8:  return 7'h00;  9:  return 7'h10;  10: return 7'h08;  11: return 7'h03;
            12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic show(input int pos, input logic [6:0] cat, input logic dpb, input int cyc);
        anode   = ~(8'd1 << pos);
        cathode = cat;
        dp      = dpb;
        repeat (cyc) tick();
    endtask

    // positions lo..hi showing glyph (pos+1)
    task automatic scan(input int lo, input int hi);
        for (int p = lo; p <= hi; p++) show(p, glyph(p + 1), 1'b1, 10);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        tick();
    endtask

    initial begin
        int base;
        int lat;

        for (int i = 0; i < 16; i++) vecs[i] = '{glyph(i), 4'(i), 1'b0};
        vecs[16] = '{7'h7F, 4'h0, 1'b1};
        vecs[17] = '{7'h7E, 4'h0, 1'b1};
        vecs[18] = '{7'h55, 4'h0, 1'b1};
        vecs[19] = '{7'h0F, 4'h0, 1'b1};

        // reset values
        #3 rst_n = 1'b0;
        #1;
        chk("rst_digits", digits, 32'h0);
        chk("rst_frame_valid", 32'(frame_valid), 32'h0);
        chk("rst_pattern_err", 32'(pattern_err), 32'h0);
        chk("rst_anode_err", 32'(anode_err), 32'h0);
`ifdef SEG7_SCAN_DP_CAPTURE_EN
        chk("rst_dp_out", 32'(dp_out), 32'h0);
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_no_frame", 32'(fv_cnt), 32'd0);

        // clean scan 1..8
        base = fv_cnt;
        scan(0, 7);
        chk("clean_frames", 32'(fv_cnt - base), 32'd1);
        chk("clean_digits", digits, 32'h87654321);
        chk("clean_pattern_err", 32'(pattern_err), 32'h0);
        chk("clean_anode_err", 32'(anode_err), 32'h0);

        // latency of the last digit to frame_valid and pulse width
        for (int p = 0; p < 7; p++) show(p, glyph(p + 8), 1'b1, 10);
        anode   = 8'h7F;
        cathode = glyph(15);
        lat     = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (frame_valid) begin
                lat = n;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd7);
        tick();
        chk("fv_one_cycle", 32'(frame_valid), 32'h0);
        repeat (3) tick();
        chk("latency_digits", digits, 32'hFEDCBA98);

        // short glitch to position 3 / F is not captured
        base = fv_cnt;
        scan(0, 4);
        show(3, glyph(15), 1'b1, 2);
        show(4, glyph(5), 1'b1, 10);
        scan(5, 7);
        chk("glitch_frames", 32'(fv_cnt - base), 32'd1);
        chk("glitch_digits", digits, 32'h87654321);
        chk("glitch_anode_err", 32'(anode_err), 32'h0);
        chk("glitch_pattern_err", 32'(pattern_err), 32'h0);

        // two anodes low: anode_err, set beats same-cycle clear, seen mask untouched
        base    = fv_cnt;
        anode   = 8'b11111100;
        cathode = glyph(9);
        dp      = 1'b1;
        repeat (6) tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("set_beats_clear", 32'(anode_err), 32'h1);
        repeat (3) tick();
        scan(2, 7);
        chk("bad_anode_no_frame", 32'(fv_cnt - base), 32'd0);
        pulse_clear();
        chk("anode_err_cleared", 32'(anode_err), 32'h0);
        scan(0, 1);
        chk("bad_anode_frames", 32'(fv_cnt - base), 32'd1);
        chk("bad_anode_digits", digits, 32'h87654321);
        chk("bad_anode_pattern_err", 32'(pattern_err), 32'h0);

        // all segments off on position 5
        base = fv_cnt;
        scan(0, 4);
        show(5, 7'h7F, 1'b1, 10);
        scan(6, 7);
        chk("blank_seg_frames", 32'(fv_cnt - base), 32'd1);
        chk("blank_seg_digits", digits, 32'h87054321);
        chk("blank_seg_pattern_err", 32'(pattern_err), 32'h1);
        chk("blank_seg_anode_err", 32'(anode_err), 32'h0);
        pulse_clear();
        chk("pattern_err_cleared", 32'(pattern_err), 32'h0);

        // table: every glyph plus some non-glyphs on all eight positions
        for (int v = 0; v < 20; v++) begin
            base = fv_cnt;
            for (int p = 0; p < 8; p++) show(p, vecs[v].cat, 1'b1, 10);
            chk($sformatf("vec%0d_digits", v), digits, {8{vecs[v].nib}});
            chk($sformatf("vec%0d_pattern_err", v), 32'(pattern_err), 32'(vecs[v].perr));
            chk($sformatf("vec%0d_frames", v), 32'(fv_cnt - base), 32'd1);
            pulse_clear();
        end

        // reset mid-frame discards the partial frame
        scan(0, 3);
        anode   = 8'hFF;
        cathode = 7'h7F;
        rst_n   = 1'b0;
        #1;
        chk("midrst_digits", digits, 32'h0);
        chk("midrst_frame_valid", 32'(frame_valid), 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        base = fv_cnt;
        scan(4, 7);
        chk("midrst_no_early_frame", 32'(fv_cnt - base), 32'd0);
        scan(0, 3);
        chk("midrst_frames", 32'(fv_cnt - base), 32'd1);
        chk("midrst_digits_after", digits, 32'h87654321);

`ifdef SEG7_SCAN_DP_CAPTURE_EN
        // decimal points low only on positions 0 and 7
        for (int p = 0; p < 8; p++) show(p, glyph(p + 1), (p == 0 || p == 7) ? 1'b0 : 1'b1, 10);
        chk("dp_out", 32'(dp_out), 32'h81);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
